// File: rtl/ccg_vector_capture.sv
// Capture harness around the CCGRCG0 netlist: drives x0..x9, samples f1..f10 after
// SETTLE edges, queues {vector, response} and folds every response into a MISR.
module ccg_vector_capture #(
    parameter int NIN    = 10,
    parameter int NOUT   = 10,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4,
    parameter int SIG_W  = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 'h1021
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIN-1:0]   in_vec,
    output logic [NIN-1:0]   x_out,
    input  logic [NOUT-1:0]  f_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIN-1:0]   out_vec,
    output logic [NOUT-1:0]  out_resp,
    input  logic             clear,
    output logic [SIG_W-1:0] sig,
    output logic [15:0]      vec_count,
    output logic             busy
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int EW  = NIN + NOUT;

    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW:0]    CNT_FULL = DEPTH[AW:0];
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [WCW-1:0] WAIT_ONE = 1;
    localparam logic [WCW-1:0] WAIT_INI = WCW'(SETTLE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [NIN-1:0]  x_q, x_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [15:0]     vcnt_q, vcnt_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             capture;
    logic             pop;
    logic [SIG_W-1:0] misr_next;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // Ready is gated by rst so nothing can be accepted while reset is asserted.
    assign in_ready = !rst && (state_q == S_IDLE) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign capture  = (state_q == S_WAIT) && (wait_q == '0);
    assign pop      = !fifo_empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d     = in_vec;
                    wait_d  = WAIT_INI;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A push never meets a full FIFO: acceptance already required a free slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({capture, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= {x_q, f_in};
        end
    end

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                     ^ SIG_W'(f_in);

    // Clear has priority over a coincident capture; the FIFO push is unaffected.
    always_comb begin
        sig_d  = sig_q;
        vcnt_d = vcnt_q;
        if (clear) begin
            sig_d  = '0;
            vcnt_d = '0;
        end else if (capture) begin
            sig_d = misr_next;
            if (vcnt_q != 16'hFFFF) begin
                vcnt_d = vcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= '0;
            vcnt_q <= '0;
        end else begin
            sig_q  <= sig_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign x_out     = x_q;
    assign out_valid = !fifo_empty;
    assign out_vec   = mem_q[rd_ptr_q][EW-1:NOUT];
    assign out_resp  = mem_q[rd_ptr_q][NOUT-1:0];
    assign sig       = sig_q;
    assign vec_count = vcnt_q;
    assign busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_ccg_vector_capture.sv
// Bench for ccg_vector_capture: a stand-in netlist drives f_in from x_out and a
// transaction-level model (expected queue, MISR arithmetic) predicts every output.
module tb_ccg_vector_capture;

    localparam int NIN    = 10;
    localparam int NOUT   = 10;
    localparam int SETTLE = 1;
    localparam int DEPTH  = 4;
    localparam int SIG_W  = 16;
    localparam logic [15:0] POLY = 16'h1021;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NIN-1:0]   in_vec = '0;
    logic [NIN-1:0]   x_out;
    logic [NOUT-1:0]  f_in;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NIN-1:0]   out_vec;
    logic [NOUT-1:0]  out_resp;
    logic             clear = 1'b0;
    logic [SIG_W-1:0] sig;
    logic [15:0]      vec_count;
    logic             busy;

    ccg_vector_capture #(
        .NIN(NIN), .NOUT(NOUT), .SETTLE(SETTLE), .DEPTH(DEPTH),
        .SIG_W(SIG_W), .SIG_POLY(POLY)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .x_out(x_out), .f_in(f_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_resp(out_resp),
        .clear(clear), .sig(sig), .vec_count(vec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the netlist: 0x011 -> 0x3FF, 0x000 -> 0x000.
    function automatic logic [9:0] netlist(input logic [9:0] x);
        if (x[0] && x[4]) return 10'h3FF;
        return x ^ {x[8:0], x[9]};
    endfunction

    assign f_in = netlist(x_out);

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [9:0] f);
        logic [15:0] n;
        n = s << 1;
        if (s[15]) n = n ^ POLY;
        return n ^ {6'd0, f};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [19:0] exp_q[$];
    logic [15:0] m_sig;
    logic [15:0] m_cnt;
    logic [9:0]  m_x;
    bit          m_busy;
    int          m_wait;
    bit          rnd_mode = 0;

    task automatic model_reset();
        exp_q.delete();
        m_sig  = '0;
        m_cnt  = '0;
        m_x    = '0;
        m_busy = 0;
        m_wait = 0;
    endtask

    // Called at posedge+1 with this cycle's inputs applied; checks, then advances one edge.
    task automatic step(output bit acc);
        bit exp_ready, pop, clr, cap;
        logic [9:0] resp;
        if (rnd_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 63) == 0);
        end
        exp_ready = !m_busy && (exp_q.size() < DEPTH);
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        check_eq("busy", busy, m_busy);
        check_eq("x_out", x_out, m_x);
        check_eq("sig", sig, m_sig);
        check_eq("vec_count", vec_count, m_cnt);
        if (exp_q.size() != 0) begin
            check_eq("out_vec", out_vec, exp_q[0][19:10]);
            check_eq("out_resp", out_resp, exp_q[0][9:0]);
        end
        acc = in_valid && exp_ready;
        pop = out_ready && (exp_q.size() != 0);
        clr = clear;
        cap = m_busy && (m_wait == 0);
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (cap) begin
            resp = netlist(m_x);
            exp_q.push_back({m_x, resp});
            m_sig = misr(m_sig, resp);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_busy = 0;
        end else if (m_busy) begin
            m_wait = m_wait - 1;
        end
        if (clr) begin
            m_sig = '0;
            m_cnt = '0;
        end
        if (acc) begin
            m_x    = in_vec;
            m_busy = 1;
            m_wait = SETTLE - 1;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send(input logic [9:0] v);
        bit a;
        int budget;
        in_valid = 1'b1;
        in_vec   = v;
        a        = 0;
        budget   = 0;
        while (!a && budget < 50) begin
            step(a);
            budget++;
        end
        if (!a) check_eq("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; returns at posedge+1 after release.
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sig", sig, 0);
        check_eq("rst_vec_count", vec_count, 0);
        check_eq("rst_x_out", x_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        apply_reset();

        // Reset while a vector is in flight, with one entry already queued
        out_ready = 1'b0;
        send(10'h155);
        idle(1);
        send(10'h2AA);
        check_eq("pre_rst_busy", busy, 1);
        apply_reset();
        check_eq("post_rst_ready", in_ready, 1);
        idle(2);

        // Directed vectors 0x011 then 0x000, checked in queue order
        send(10'h011);
        idle(1);
        check_eq("t2_sig", sig, 16'h03FF);
        check_eq("t2_resp", out_resp, 10'h3FF);
        send(10'h000);
        idle(1);
        check_eq("t3_sig", sig, 16'h07FE);
        check_eq("t3_count", vec_count, 2);
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;

        // Fill the FIFO, hold a fifth vector, release with a single pop
        for (int i = 0; i < DEPTH; i++) begin
            send(10'($urandom_range(0, 1023)));
            idle(1);
        end
        check_eq("full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_vec   = 10'h3C3;
        idle(3);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        send(10'h3C3);
        idle(1);
        out_ready = 1'b1;
        idle(6);
        out_ready = 1'b0;

        // Clear coinciding with the capture of 0x011
        apply_reset();
        send(10'h000);
        idle(1);
        send(10'h011);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check_eq("t5_sig", sig, 0);
        check_eq("t5_count", vec_count, 0);
        out_ready = 1'b1;
        idle(1);
        check_eq("t5_head_vec", out_vec, 10'h011);
        check_eq("t5_head_resp", out_resp, 10'h3FF);
        idle(2);
        out_ready = 1'b0;

        // One entry queued, pop coinciding with the next capture
        send(10'h0F0);
        idle(1);
        send(10'h00F);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check_eq("t6_head", out_vec, 10'h00F);
        idle(1);

        // Randomised run
        rnd_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            send(10'($urandom_range(0, 1023)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_mode  = 0;
        clear     = 1'b0;
        out_ready = 1'b1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
